// File: rtl/modexp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer: default
// widths, FSM state encoding and multiplier B-operand select codes.
// The CONV_* states are only reached when MODEXP_FINAL_CONV_EN is defined.
package modexp_ctrl_pkg;

  localparam int DEF_WIDTH  = 1024;
  localparam int DEF_ELEN_W = 11;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD       = 4'd1,
    ST_SQ_ISSUE   = 4'd2,
    ST_SQ_WAIT    = 4'd3,
    ST_MUL_ISSUE  = 4'd4,
    ST_MUL_WAIT   = 4'd5,
    ST_NEXT       = 4'd6,
    ST_CONV_ISSUE = 4'd7,
    ST_CONV_WAIT  = 4'd8,
    ST_FIN        = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    B_SEL_A   = 2'd0,
    B_SEL_X   = 2'd1,
    B_SEL_ONE = 2'd2
  } b_sel_t;

endpackage

// File: rtl/modexp_bit_iter.sv
// Exponent bit iterator: holds E left-aligned so the current bit e[i] is
// always the MSB, plus a down-counter on i so the controller knows when the
// last (i==0) bit is being processed.
module modexp_bit_iter
  import modexp_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ELEN_W = DEF_ELEN_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              advance,
  input  logic [WIDTH-1:0]  e_in,
  input  logic [ELEN_W-1:0] len_in,
  output logic              cur_bit,
  output logic              last
);

  localparam logic [ELEN_W-1:0] WIDTH_L = ELEN_W'(WIDTH);
  localparam logic [ELEN_W-1:0] ONE_L   = {{(ELEN_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]  e_sr_r;
  logic [ELEN_W-1:0] idx_r;
  logic [ELEN_W-1:0] shift_s;

  // Left-align bit e_len-1 at the MSB; bits above it fall off the top.
  assign shift_s = WIDTH_L - len_in;

  // Shift register and index counter: load on accept, step once per bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_sr_r <= {WIDTH{1'b0}};
      idx_r  <= {ELEN_W{1'b0}};
    end else if (load) begin
      e_sr_r <= e_in << shift_s;
      idx_r  <= len_in - ONE_L;
    end else if (advance) begin
      e_sr_r <= {e_sr_r[WIDTH-2:0], 1'b0};
      idx_r  <= idx_r - ONE_L;
    end
  end

  assign cur_bit = e_sr_r[WIDTH-1];
  assign last    = (idx_r == {ELEN_W{1'b0}});

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer driving one external
// Montgomery multiplier. Computes A = X^E in the Montgomery domain.
// Optional feature macro: MODEXP_FINAL_CONV_EN -- adds a final multiply by 1
// (CONV_ISSUE/CONV_WAIT) so the result leaves the Montgomery domain.
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ELEN_W = DEF_ELEN_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_r,
  input  logic [WIDTH-1:0]  in_e,
  input  logic [ELEN_W-1:0] e_len,
  input  logic [WIDTH-1:0]  in_m,
  output logic              mm_start,
  output logic [WIDTH-1:0]  mm_a,
  output logic [WIDTH-1:0]  mm_b,
  output logic [WIDTH-1:0]  mm_m,
  input  logic [WIDTH-1:0]  mm_result,
  input  logic              mm_done,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              busy
);

  localparam logic [WIDTH-1:0] MONT_ONE_L = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef MODEXP_FINAL_CONV_EN
  localparam state_t ST_TAIL = ST_CONV_ISSUE;
`else
  localparam state_t ST_TAIL = ST_FIN;
`endif

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] x_r;

  logic   start_acc_s;
  logic   issue_s;
  b_sel_t b_sel_s;
  logic   capture_s;
  logic   done_s;
  logic   advance_s;
  logic   iter_bit_s;
  logic   iter_last_s;

  // A start is taken only in IDLE and not during the trailing done cycle.
  assign start_acc_s = start && (state_r == ST_IDLE) && !busy;

  modexp_bit_iter #(
    .WIDTH  (WIDTH),
    .ELEN_W (ELEN_W)
  ) u_bit_iter (
    .clk     (clk),
    .resetn  (resetn),
    .load    (start_acc_s),
    .advance (advance_s),
    .e_in    (in_e),
    .len_in  (e_len),
    .cur_bit (iter_bit_s),
    .last    (iter_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; mm_done only matters in the wait states.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_acc_s) begin
          state_nxt_s = (e_len == {ELEN_W{1'b0}}) ? ST_TAIL : ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD:      state_nxt_s = ST_SQ_ISSUE;
      ST_SQ_ISSUE:  state_nxt_s = ST_SQ_WAIT;
      ST_SQ_WAIT: begin
        if (mm_done) begin
          state_nxt_s = iter_bit_s ? ST_MUL_ISSUE : ST_NEXT;
        end else begin
          state_nxt_s = ST_SQ_WAIT;
        end
      end
      ST_MUL_ISSUE: state_nxt_s = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mm_done) begin
          state_nxt_s = ST_NEXT;
        end else begin
          state_nxt_s = ST_MUL_WAIT;
        end
      end
      ST_NEXT:      state_nxt_s = iter_last_s ? ST_TAIL : ST_SQ_ISSUE;
`ifdef MODEXP_FINAL_CONV_EN
      ST_CONV_ISSUE: state_nxt_s = ST_CONV_WAIT;
      ST_CONV_WAIT: begin
        if (mm_done) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_CONV_WAIT;
        end
      end
`endif
      ST_FIN:       state_nxt_s = ST_IDLE;
      default:      state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode; these strobes feed the registered datapath below.
  always_comb begin
    issue_s   = 1'b0;
    b_sel_s   = B_SEL_A;
    capture_s = 1'b0;
    done_s    = 1'b0;
    advance_s = 1'b0;
    case (state_r)
      ST_SQ_ISSUE: begin
        issue_s = 1'b1;
        b_sel_s = B_SEL_A;
      end
      ST_MUL_ISSUE: begin
        issue_s = 1'b1;
        b_sel_s = B_SEL_X;
      end
      ST_SQ_WAIT, ST_MUL_WAIT: capture_s = mm_done;
`ifdef MODEXP_FINAL_CONV_EN
      ST_CONV_ISSUE: begin
        issue_s = 1'b1;
        b_sel_s = B_SEL_ONE;
      end
      ST_CONV_WAIT: capture_s = mm_done;
`endif
      ST_NEXT:     advance_s = !iter_last_s;
      ST_FIN:      done_s    = 1'b1;
      default: begin
        issue_s   = 1'b0;
        capture_s = 1'b0;
      end
    endcase
  end

  // Accumulator, operand latches and all registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_r      <= {WIDTH{1'b0}};
      x_r      <= {WIDTH{1'b0}};
      mm_a     <= {WIDTH{1'b0}};
      mm_b     <= {WIDTH{1'b0}};
      mm_m     <= {WIDTH{1'b0}};
      result   <= {WIDTH{1'b0}};
      mm_start <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mm_start <= issue_s;
      done     <= done_s;
      if (start_acc_s) begin
        x_r  <= in_x;
        mm_m <= in_m;
        a_r  <= in_r;
      end else if (capture_s) begin
        a_r  <= mm_result;
      end
      // Operands change only at issue, so they hold through mm_done.
      if (issue_s) begin
        mm_a <= a_r;
        case (b_sel_s)
          B_SEL_A:   mm_b <= a_r;
          B_SEL_X:   mm_b <= x_r;
          B_SEL_ONE: mm_b <= MONT_ONE_L;
          default:   mm_b <= a_r;
        endcase
      end
      if (done_s) begin
        result <= a_r;
      end
      // busy covers the accept cycle onward and drops after the done cycle.
      if (start_acc_s) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl at WIDTH=16 with a behavioural
// Montgomery multiplier (R = 2^16, random 1..20 cycle latency).
module tb_modexp_ctrl;

  localparam int W     = 16;
  localparam int EW    = 5;
  localparam int BOUND = 3000;
`ifdef MODEXP_FINAL_CONV_EN
  localparam int CONV = 1;
`else
  localparam int CONV = 0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0, in_r = '0, in_e = '0, in_m = '0;
  logic [EW-1:0] e_len = '0;
  logic          mm_start, mm_done, done, busy;
  logic [W-1:0]  mm_a, mm_b, mm_m, mm_result, result;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  modexp_ctrl #(.WIDTH(W), .ELEN_W(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_r(in_r), .in_e(in_e), .e_len(e_len), .in_m(in_m),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done),
    .result(result), .done(done), .busy(busy)
  );

  // ---------------- behavioural Montgomery multiplier ----------------
  logic         mdl_done = 1'b0;
  logic         spur_done = 1'b0;
  logic         mdl_busy = 1'b0;
  logic [W-1:0] mdl_res = '0;
  logic [W-1:0] cap_a = '0, cap_b = '0, cap_m = '0;
  int           mdl_lat = 0;
  int           pulse_cnt = 0;
  int           unstable_cnt = 0;

  assign mm_done   = mdl_done | spur_done;
  assign mm_result = mdl_res;

  function automatic longint mont(longint a, longint b, longint m);
    longint r, rinv;
    r = 65536 % m;
    rinv = 0;
    for (longint k = 1; k < m; k++) begin
      if ((r * k) % m == 1) rinv = k;
    end
    return (((a * b) % m) * rinv) % m;
  endfunction

  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (!resetn) begin
      mdl_busy <= 1'b0;
    end else if (mm_start) begin
      cap_a     <= mm_a;
      cap_b     <= mm_b;
      cap_m     <= mm_m;
      mdl_lat   <= $urandom_range(20, 1);
      mdl_busy  <= 1'b1;
      pulse_cnt <= pulse_cnt + 1;
    end else if (mdl_busy) begin
      if (mm_a !== cap_a || mm_b !== cap_b || mm_m !== cap_m) unstable_cnt <= unstable_cnt + 1;
      if (mdl_lat <= 1) begin
        mdl_done <= 1'b1;
        mdl_res  <= W'(mont(longint'(cap_a), longint'(cap_b), longint'(cap_m)));
        mdl_busy <= 1'b0;
      end else begin
        mdl_lat <= mdl_lat - 1;
      end
    end
  end

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int masked_e(int e, int elen);
    return (elen >= 16) ? e : (e & ((1 << elen) - 1));
  endfunction

  function automatic int exp_result(int x, int e, int elen, int m);
    longint pw;
    int em;
    em = masked_e(e, elen);
    pw = 1 % m;
    for (int k = 0; k < em; k++) pw = (pw * x) % m;
    if (CONV != 0) return int'(pw);
    return int'((pw * (65536 % m)) % m);
  endfunction

  function automatic int exp_pulses(int e, int elen);
    int em, pc;
    em = masked_e(e, elen);
    pc = 0;
    for (int k = 0; k < 16; k++) pc += (em >> k) & 1;
    return elen + pc + CONV;
  endfunction

  // Runs one exponentiation; returns observations only, no checking here.
  task automatic do_run(input int x, input int e, input int elen, input int m,
                        input bit repulse, input bit spur,
                        output int res, output int pulses, output int lat,
                        output logic busy1, output logic done_after, output logic busy_after);
    int p0, cyc;
    longint r;
    r = 65536 % m;
    @(negedge clk);
    in_m  = W'(m);
    in_r  = W'(r);
    in_x  = W'((longint'(x) * r) % m);
    in_e  = W'(e);
    e_len = EW'(elen);
    start = 1'b1;
    p0 = pulse_cnt;
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    cyc = 1;
    while (done !== 1'b1 && cyc < BOUND) begin
      spur_done = spur && (cyc == 2);
      start = repulse && (cyc == 4 || cyc == 9);
      @(negedge clk);
      cyc++;
    end
    spur_done = 1'b0;
    start = 1'b0;
    res = int'(result);
    pulses = pulse_cnt - p0;
    lat = (done === 1'b1) ? cyc : -1;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int p0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({mm_start, done, busy} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {mm_start, done, busy});
    else n_pass++;
    n_total++;
    if ({result, mm_a, mm_b, mm_m} !== {(4*W){1'b0}}) $display("FAIL reset_data: got %h/%h/%h/%h expected zeros", result, mm_a, mm_b, mm_m);
    else n_pass++;
    resetn = 1'b1;
    p0 = pulse_cnt;
    repeat (10) @(negedge clk);
    n_total++;
    if (done !== 1'b0 || pulse_cnt != p0) $display("FAIL idle_quiet: done=%b pulses=%0d expected 0/0", done, pulse_cnt - p0);
    else n_pass++;
  endtask

  task automatic test_basic();
    int res, pulses, lat;
    logic b1, da, ba;
    do_run(2, 5, 3, 13, 1'b0, 1'b0, res, pulses, lat, b1, da, ba);
    n_total++;
    if (res != exp_result(2, 5, 3, 13)) $display("FAIL basic_result: got %0d expected %0d", res, exp_result(2, 5, 3, 13));
    else n_pass++;
    n_total++;
    if (pulses != exp_pulses(5, 3)) $display("FAIL basic_pulses: got %0d expected %0d", pulses, exp_pulses(5, 3));
    else n_pass++;
    n_total++;
    if (b1 !== 1'b1) $display("FAIL basic_busy: got %b expected 1", b1);
    else n_pass++;
    n_total++;
    if ({da, ba} !== 2'b00) $display("FAIL basic_end: done/busy after got %b expected 00", {da, ba});
    else n_pass++;
    repeat (5) @(negedge clk);
    n_total++;
    if (int'(result) != res) $display("FAIL result_hold: got %0d expected %0d", result, res);
    else n_pass++;
  endtask

  task automatic test_zero_exp();
    int res, pulses, lat, x;
    logic b1, da, ba;
    x = $urandom_range(12, 1);
    do_run(x, 0, 4, 13, 1'b0, 1'b0, res, pulses, lat, b1, da, ba);
    n_total++;
    if (res != exp_result(x, 0, 4, 13)) $display("FAIL zero_exp_result: got %0d expected %0d", res, exp_result(x, 0, 4, 13));
    else n_pass++;
    n_total++;
    if (pulses != exp_pulses(0, 4)) $display("FAIL zero_exp_pulses: got %0d expected %0d", pulses, exp_pulses(0, 4));
    else n_pass++;
  endtask

  task automatic test_elen_zero();
    int res, pulses, lat, e;
    logic b1, da, ba;
    e = $urandom_range(65535, 1);
    do_run(7, e, 0, 13, 1'b0, 1'b0, res, pulses, lat, b1, da, ba);
    n_total++;
    if (res != exp_result(7, e, 0, 13)) $display("FAIL elen0_result: got %0d expected %0d", res, exp_result(7, e, 0, 13));
    else n_pass++;
    n_total++;
    if (pulses != CONV) $display("FAIL elen0_pulses: got %0d expected %0d", pulses, CONV);
    else n_pass++;
`ifndef MODEXP_FINAL_CONV_EN
    n_total++;
    if (lat != 2) $display("FAIL elen0_latency: got %0d expected 2", lat);
    else n_pass++;
`endif
    n_total++;
    if ({da, ba} !== 2'b00) $display("FAIL elen0_end: done/busy after got %b expected 00", {da, ba});
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int res, pulses, lat;
    logic b1, da, ba;
    do_run(2, 5, 3, 13, 1'b1, 1'b1, res, pulses, lat, b1, da, ba);
    n_total++;
    if (res != exp_result(2, 5, 3, 13)) $display("FAIL ignore_result: got %0d expected %0d", res, exp_result(2, 5, 3, 13));
    else n_pass++;
    n_total++;
    if (pulses != exp_pulses(5, 3)) $display("FAIL ignore_pulses: got %0d expected %0d", pulses, exp_pulses(5, 3));
    else n_pass++;
    n_total++;
    if ({da, ba} !== 2'b00) $display("FAIL ignore_end: done/busy after got %b expected 00", {da, ba});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int p0, cyc, res, pulses, lat;
    logic saw_done, b1, da, ba;
    @(negedge clk);
    in_m = 16'd13; in_r = 16'd3; in_x = 16'd6; in_e = 16'd5; e_len = 5'd3;
    start = 1'b1;
    p0 = pulse_cnt;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ((pulse_cnt - p0) < 2 && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if ((pulse_cnt - p0) != 2) $display("FAIL mid_reach_mul: pulses got %0d expected 2", pulse_cnt - p0);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_total++;
    if ({mm_start, done, busy, result, mm_a, mm_b, mm_m} !== {(3+4*W){1'b0}})
      $display("FAIL mid_reset_async: got %b/%h/%h/%h/%h expected zeros", {mm_start, done, busy}, result, mm_a, mm_b, mm_m);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({mm_start, done, busy, result} !== {(3+W){1'b0}}) $display("FAIL mid_reset_edge: got %b/%h expected zeros", {mm_start, done, busy}, result);
    else n_pass++;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    p0 = pulse_cnt;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || mm_start === 1'b1) saw_done = 1'b1;
    end
    n_total++;
    if (saw_done !== 1'b0 || pulse_cnt != p0) $display("FAIL mid_quiet: activity=%b pulses=%0d expected 0/0", saw_done, pulse_cnt - p0);
    else n_pass++;
    do_run(2, 5, 3, 13, 1'b0, 1'b0, res, pulses, lat, b1, da, ba);
    n_total++;
    if (res != exp_result(2, 5, 3, 13) || pulses != exp_pulses(5, 3))
      $display("FAIL mid_rerun: got %0d/%0d expected %0d/%0d", res, pulses, exp_result(2, 5, 3, 13), exp_pulses(5, 3));
    else n_pass++;
  endtask

  task automatic test_random();
    int mods[5] = '{13, 11, 97, 251, 999};
    int m, x, e, elen, res, pulses, lat;
    logic b1, da, ba;
    for (int it = 0; it < 12; it++) begin
      m    = mods[$urandom_range(4, 0)];
      x    = $urandom_range(m - 1, 0);
      e    = $urandom_range(65535, 0);
      elen = $urandom_range(16, 0);
      do_run(x, e, elen, m, 1'b0, 1'b0, res, pulses, lat, b1, da, ba);
      n_total++;
      if (res != exp_result(x, e, elen, m))
        $display("FAIL rand_result[%0d]: x=%0d e=%0d len=%0d m=%0d got %0d expected %0d", it, x, e, elen, m, res, exp_result(x, e, elen, m));
      else n_pass++;
      n_total++;
      if (pulses != exp_pulses(e, elen))
        $display("FAIL rand_pulses[%0d]: got %0d expected %0d", it, pulses, exp_pulses(e, elen));
      else n_pass++;
    end
    n_total++;
    if (unstable_cnt != 0) $display("FAIL operand_stability: got %0d changes expected 0", unstable_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_exp();
    test_elen_zero();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
